// File: rtl/pattern_detect_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package pattern_detect_pkg;

    localparam int MAX_PATTERN_LEN = 16;

    // Power-up pattern and mask: all ones, sliced down to PATTERN_LEN by the user.
    localparam logic [MAX_PATTERN_LEN-1:0] DEFAULT_PATTERN = '1;
    localparam logic [MAX_PATTERN_LEN-1:0] DEFAULT_MASK    = '1;

    function automatic int fill_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/pattern_history_shift.sv
// History shift register: newest bit enters at the LSB; exposes the value it will hold after the next shift.
// Latency: 1 cycle; no backpressure (shift_en_i qualifies each sample).
module pattern_history_shift #(
    parameter int LEN = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           shift_en_i,
    input  logic           clear_i,
    input  logic           din_i,
    output logic [LEN-1:0] hist_next_o
);

    logic [LEN-1:0] hist_q;
    logic [LEN-1:0] hist_d;

    assign hist_next_o = {hist_q[LEN-2:0], din_i};

    always_comb begin
        hist_d = hist_q;
        if (clear_i)
            hist_d = '0;
        else if (shift_en_i)
            hist_d = hist_next_o;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            hist_q <= '0;
        else
            hist_q <= hist_d;
    end

endmodule

// File: rtl/pattern_sequence_detector.sv
// Serial pattern detector with per-bit don't-care mask, overlap control and saturating match counter.
// Latency: match pulses the cycle after the final pattern bit is sampled; no backpressure.
module pattern_sequence_detector
    import pattern_detect_pkg::*;
#(
    parameter int PATTERN_LEN = 4,
    parameter int COUNT_WIDTH = 8,
    parameter int FILL_WIDTH  = fill_width(PATTERN_LEN)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   w,
    input  logic                   load,
    input  logic [PATTERN_LEN-1:0] pattern_in,
    input  logic [PATTERN_LEN-1:0] mask_in,
    input  logic                   overlap,
    input  logic                   clear_count,
    output logic                   match,
    output logic [COUNT_WIDTH-1:0] match_count,
    output logic [FILL_WIDTH-1:0]  fill
);

    localparam logic [FILL_WIDTH-1:0]  FULL    = FILL_WIDTH'(PATTERN_LEN);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    logic [PATTERN_LEN-1:0] pattern_q, mask_q;
    logic [FILL_WIDTH-1:0]  fill_q, fill_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   match_q;
    logic [PATTERN_LEN-1:0] hist_next;
    logic [FILL_WIDTH-1:0]  fill_inc;
    logic                   sample;
    logic                   hit;

    pattern_history_shift #(
        .LEN (PATTERN_LEN)
    ) u_hist (
        .clock       (clock),
        .reset       (reset),
        .shift_en_i  (sample),
        .clear_i     (load),
        .din_i       (w),
        .hist_next_o (hist_next)
    );

    // fill encodes the state: < FULL is FILLING, == FULL is ARMED, forced to 0 on a non-overlap match.
    always_comb begin
        sample   = enable & ~load;
        fill_inc = (fill_q == FULL) ? FULL : fill_q + FILL_WIDTH'(1);
        hit      = sample && (fill_inc == FULL) &&
                   (&((hist_next ~^ pattern_q) | ~mask_q));

        fill_d = fill_q;
        if (load)
            fill_d = '0;
        else if (sample)
            fill_d = (hit && !overlap) ? '0 : fill_inc;

        count_d = count_q;
        if (clear_count)
            count_d = '0;
        else if (hit && count_q != CNT_MAX)
            count_d = count_q + COUNT_WIDTH'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pattern_q <= DEFAULT_PATTERN[PATTERN_LEN-1:0];
            mask_q    <= DEFAULT_MASK[PATTERN_LEN-1:0];
            fill_q    <= '0;
            count_q   <= '0;
            match_q   <= 1'b0;
        end else begin
            if (load) begin
                pattern_q <= pattern_in;
                mask_q    <= mask_in;
            end
            fill_q  <= fill_d;
            count_q <= count_d;
            match_q <= hit;
        end
    end

    assign match       = match_q;
    assign match_count = count_q;
    assign fill        = fill_q;

endmodule

// File: tb/tb_pattern_sequence_detector.sv
// Directed bench for pattern_sequence_detector (LEN=4, COUNT_WIDTH=2) against a queue-based reference model.
module tb_pattern_sequence_detector;

    localparam int LEN = 4;
    localparam int CW  = 2;
    localparam int FW  = 3;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           enable = 1'b0;
    logic           w = 1'b0;
    logic           load = 1'b0;
    logic           overlap = 1'b0;
    logic           clear_count = 1'b0;
    logic [LEN-1:0] pattern_in = '0;
    logic [LEN-1:0] mask_in = '0;
    logic           match;
    logic [CW-1:0]  match_count;
    logic [FW-1:0]  fill;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    pattern_sequence_detector #(
        .PATTERN_LEN (LEN),
        .COUNT_WIDTH (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .w           (w),
        .load        (load),
        .pattern_in  (pattern_in),
        .mask_in     (mask_in),
        .overlap     (overlap),
        .clear_count (clear_count),
        .match       (match),
        .match_count (match_count),
        .fill        (fill)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: bits sampled since the last restart, oldest first.
    bit             hq[$];
    int             m_cnt = 0;
    bit             m_match = 1'b0;
    logic [LEN-1:0] m_pat = '1;
    logic [LEN-1:0] m_msk = '1;
    bit             m_hit;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            hq.delete();
            m_cnt   = 0;
            m_match = 1'b0;
            m_pat   = '1;
            m_msk   = '1;
        end else begin
            m_hit = 1'b0;
            if (load) begin
                m_pat = pattern_in;
                m_msk = mask_in;
                hq.delete();
            end else if (enable) begin
                hq.push_back(w);
                if (hq.size() > LEN) void'(hq.pop_front());
                if (hq.size() == LEN) begin
                    m_hit = 1'b1;
                    for (int i = 0; i < LEN; i++)
                        if (m_msk[LEN-1-i] && (hq[i] != m_pat[LEN-1-i])) m_hit = 1'b0;
                end
                if (m_hit && !overlap) hq.delete();
            end
            m_match = m_hit;
            if (clear_count) m_cnt = 0;
            else if (m_hit && m_cnt < (1 << CW) - 1) m_cnt++;
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk("model_match", 32'(match), 32'(m_match));
            chk("model_count", 32'(match_count), 32'(m_cnt));
            chk("model_fill", 32'(fill), 32'(hq.size()));
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic send(input bit b);
        load   = 1'b0;
        enable = 1'b1;
        w      = b;
        tick();
    endtask

    task automatic send_seq(input logic [15:0] bits, input int n);
        logic [15:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) send(v[i]);
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        load   = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_load(input logic [LEN-1:0] p, input logic [LEN-1:0] m);
        enable     = 1'b0;
        load       = 1'b1;
        pattern_in = p;
        mask_in    = m;
        tick();
        load = 1'b0;
    endtask

    task automatic clr();
        enable      = 1'b0;
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        chk("reset_fill", 32'(fill), 0);
        chk("reset_match", 32'(match), 0);
        chk("reset_count", 32'(match_count), 0);

        // Default 1111 pattern, then an asynchronous reset with fill at 3.
        overlap = 1'b0;
        send_seq(16'b1111, 4);
        chk("dflt_match", 32'(match), 1);
        chk("dflt_count", 32'(match_count), 1);
        send_seq(16'b111, 3);
        chk("pre_rst_fill", 32'(fill), 3);
        enable = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("async_rst_fill", 32'(fill), 0);
        chk("async_rst_match", 32'(match), 0);
        chk("async_rst_count", 32'(match_count), 0);
        @(posedge clock);
        #2 reset = 1'b0;

        // Overlapping 1101 on 1101101.
        overlap = 1'b1;
        do_load(4'b1101, 4'b1111);
        send_seq(16'b110, 3);
        send(1'b1);
        chk("ovl_match4", 32'(match), 1);
        send(1'b1);
        chk("ovl_match5", 32'(match), 0);
        send_seq(16'b01, 2);
        chk("ovl_match7", 32'(match), 1);
        chk("ovl_count", 32'(match_count), 2);
        idle(1);
        clr();

        // Non-overlapping on the same stream.
        overlap = 1'b0;
        do_load(4'b1101, 4'b1111);
        send_seq(16'b1101, 4);
        chk("novl_match4", 32'(match), 1);
        send_seq(16'b101, 3);
        chk("novl_match7", 32'(match), 0);
        chk("novl_fill", 32'(fill), 3);
        chk("novl_count", 32'(match_count), 1);
        idle(1);
        clr();

        // Mask 1011: the second-arriving bit is ignored.
        do_load(4'b1101, 4'b1011);
        send_seq(16'b1001, 4);
        chk("mask_dc_match", 32'(match), 1);
        send_seq(16'b1011, 4);
        chk("mask_miss_match", 32'(match), 0);
        chk("mask_miss_fill", 32'(fill), 4);
        send_seq(16'b1101, 4);
        chk("mask_hit_match", 32'(match), 1);
        chk("mask_count", 32'(match_count), 2);
        clr();

        // Enable low mid-pattern freezes progress.
        do_load(4'b1101, 4'b1111);
        send_seq(16'b11, 2);
        idle(3);
        chk("frozen_fill", 32'(fill), 2);
        chk("frozen_match", 32'(match), 0);
        send_seq(16'b01, 2);
        chk("resume_match", 32'(match), 1);
        chk("resume_count", 32'(match_count), 1);
        clr();

        // Mask all zero, overlap: every full-window sample matches; counter saturates at 3.
        overlap = 1'b1;
        do_load(4'b1101, 4'b0000);
        send_seq(16'b101, 3);
        chk("sat_fill3_match", 32'(match), 0);
        send(1'b0);
        chk("sat_first_match", 32'(match), 1);
        chk("sat_first_count", 32'(match_count), 1);
        send_seq(16'b0110, 4);
        chk("sat_count", 32'(match_count), 3);
        clear_count = 1'b1;
        send(1'b1);
        clear_count = 1'b0;
        chk("clr_win_match", 32'(match), 1);
        chk("clr_win_count", 32'(match_count), 0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
